// File: rtl/clk_divider_pkg.sv
// ---------------------------------------------------------------------------
// clk_divider_pkg
// Shared types and constants for the programmable integer clock divider.
//   DIV_W_DEFAULT : default ratio / counter width
//   div_ratio_t   : ratio type at the default width
//   DIV_OFF       : ratio value that stops the divider (output held low)
//   DIV_BYPASS    : ratio value that routes clk_in straight to clk_out
// ---------------------------------------------------------------------------
package clk_divider_pkg;

  localparam int DIV_W_DEFAULT = 8;

  typedef logic [DIV_W_DEFAULT-1:0] div_ratio_t;

  localparam int DIV_OFF    = 0;
  localparam int DIV_BYPASS = 1;

endpackage

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
// Period counter for the clock divider. Counts 0..N-1 and wraps. Reports the
// count that is about to be loaded and whether the divided clock should be
// high during that count (high while count < floor(N/2)).
// Ports:
//   clk        : divider clock (clk_in)
//   rst        : synchronous active-high reset (power_down)
//   ratio      : latched division ratio N
//   count_next : count value loaded on this edge
//   phase_next : 1 when the divided clock is high for count_next
//   wrap       : 1 on the edge where the counter returns from N-1 to 0
// ---------------------------------------------------------------------------
module clk_div_counter
  import clk_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] ratio,
  output logic [DIV_W-1:0] count_next,
  output logic             phase_next,
  output logic             wrap
);

  logic [DIV_W-1:0] count;
  logic             run;
  logic             active;
  logic [DIV_W-1:0] half;

  // Ratios 0 and 1 never use the counter.
  assign active = (ratio > DIV_W'(DIV_BYPASS));
  assign half   = ratio >> 1;

  // The first edge after reset release loads count 0 (rather than
  // incrementing) so that edge already starts the high phase.
  always_comb begin
    count_next = '0;
    wrap       = 1'b0;
    if (run && active) begin
      if (count == ratio - DIV_W'(1)) begin
        wrap = 1'b1;
      end else begin
        count_next = count + DIV_W'(1);
      end
    end
  end

  assign phase_next = active && (count_next < half);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      run   <= 1'b0;
    end else begin
      count <= count_next;
      run   <= 1'b1;
    end
  end

endmodule

// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
// Programmable integer clock divider. Divides clk_in by the ratio N latched
// from divide_by; clk_out is high for floor(N/2) cycles and low for the rest.
// N=0 holds clk_out low, N=1 passes clk_in through.
// Ports:
//   clk_in     : DCO clock, the only clock in the block
//   power_down : synchronous active-high reset; also loads divide_by into N
//   divide_by  : division ratio N
//   clk_out    : divided clock (registered except in the N=1 bypass)
// Build option:
//   CLK_DIVIDER_LIVE_UPDATE_EN : when defined, divide_by is also re-sampled
//   while running, but only at the period boundary (counter wrap), so a
//   ratio change never produces a runt pulse.
// ---------------------------------------------------------------------------
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             power_down,
  input  logic [DIV_W-1:0] divide_by,
  output logic             clk_out
);

  logic [DIV_W-1:0] ratio;
  logic [DIV_W-1:0] count_next;
  logic             phase_next;
  logic             wrap;
  logic             clk_q;
  logic             bypass;

  clk_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clk        (clk_in),
    .rst        (power_down),
    .ratio      (ratio),
    .count_next (count_next),
    .phase_next (phase_next),
    .wrap       (wrap)
  );

  always_ff @(posedge clk_in) begin
    if (power_down) begin
      ratio <= divide_by;
`ifdef CLK_DIVIDER_LIVE_UPDATE_EN
    end else if (wrap) begin
      ratio <= divide_by;
`endif
    end
  end

  // phase_next is already forced low for N=0 and N=1.
  always_ff @(posedge clk_in) begin
    if (power_down) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= phase_next;
    end
  end

  // Select is driven only by the ratio register, so it is static between
  // ratio loads and the mux cannot glitch on its own.
  assign bypass  = (ratio == DIV_W'(DIV_BYPASS));
  assign clk_out = bypass ? clk_in : clk_q;

  // Count value is consumed inside the counter; only the flags are used here.
  logic unused_count;
  assign unused_count = ^count_next;

endmodule

// File: tb/tb_clk_divider.sv
module tb_clk_divider;

  logic       clk_in;
  logic       power_down;
  logic [7:0] divide_by;
  logic       clk_out;

  int n_cmp = 0;
  int n_bad = 0;

  clk_divider #(.DIV_W(8)) dut (
    .clk_in     (clk_in),
    .power_down (power_down),
    .divide_by  (divide_by),
    .clk_out    (clk_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    int n;
    int h;
    int l;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: clk_out=%b expected=%b at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Assert power_down for one edge with ratio n, check output is low, release.
  task automatic load_ratio(input int n);
    power_down = 1'b1;
    divide_by  = 8'(n);
    @(posedge clk_in); #1;
    if (n != 1) chk("pd_low", n, clk_out, 1'b0);
    power_down = 1'b0;
  endtask

  // Sample one value per cycle, #1 after each rising edge.
  task automatic run_check(input string name, input int h, input int l, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk_in); #1;
      chk(name, k, clk_out, ((k % (h + l)) < h) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{2,   1,   1};
    vecs[1] = '{4,   2,   2};
    vecs[2] = '{8,   4,   4};
    vecs[3] = '{16,  8,   8};
    vecs[4] = '{32,  16,  16};
    vecs[5] = '{64,  32,  32};
    vecs[6] = '{5,   2,   3};
    vecs[7] = '{255, 127, 128};

    power_down = 1'b1;
    divide_by  = 8'd2;
    @(posedge clk_in); #1;
    chk("reset", 0, clk_out, 1'b0);
    @(posedge clk_in); #1;
    chk("reset", 1, clk_out, 1'b0);
    power_down = 1'b0;

    // Table-driven ratios: two full periods each, at least 100 cycles.
    for (int v = 0; v < 8; v++) begin
      load_ratio(vecs[v].n);
      run_check("ratio", vecs[v].h, vecs[v].l,
                (2 * vecs[v].n > 100) ? 2 * vecs[v].n : 100);
    end

    // N=0: divider off.
    load_ratio(0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in); #1;
      chk("off", k, clk_out, 1'b0);
    end

    // N=1: clk_out follows clk_in.
    load_ratio(1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in); #1;
      chk("bypass_hi", k, clk_out, 1'b1);
      @(negedge clk_in); #1;
      chk("bypass_lo", k, clk_out, 1'b0);
    end

    // Ratio change 4 -> 8 while running.
    load_ratio(4);
    @(posedge clk_in); #1;
    chk("live", 0, clk_out, 1'b1);
    divide_by = 8'd8;
    for (int k = 1; k < 36; k++) begin
      logic exp;
      @(posedge clk_in); #1;
`ifdef CLK_DIVIDER_LIVE_UPDATE_EN
      if (k < 4) exp = ((k % 4) < 2);
      else       exp = (((k - 4) % 8) < 4);
`else
      exp = ((k % 4) < 2);
`endif
      chk("live", k, clk_out, exp);
    end

    // power_down in the high phase at N=16.
    load_ratio(16);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in); #1;
      chk("mid_pd_pre", k, clk_out, 1'b1);
    end
    power_down = 1'b1;
    @(posedge clk_in); #1;
    chk("mid_pd_cut", 0, clk_out, 1'b0);
    power_down = 1'b0;
    run_check("mid_pd_restart", 8, 8, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Programmable integer clock divider.
- Divides the DCO clock (clk_in) by an 8-bit ratio taken from the divider control register.
- Output drives the FLB sample clock (nsh_clk).
- power_down doubles as the block's synchronous reset and as the ratio-load strobe.

Parameters:
- DIV_W, default 8, width of divide_by and of the internal period counter.

Ports:
- clk_in  input  1  DCO clock; only clock in the block; all state updates on its rising edge.
- power_down  input  1  synchronous active-high reset; also loads divide_by into the ratio register.
- divide_by  input  DIV_W  division ratio N from the control register.
- clk_out  output  1  divided clock to the FLB nsh_clk.

Behaviour:
- Reset is synchronous and active-high: power_down is sampled on the clk_in rising edge.
- While power_down=1, every edge:
  - counter <= 0;
  - clk_out register <= 0;
  - ratio register N <= divide_by.
- While power_down=0, divide_by is ignored. Changes take effect only after the next power_down pulse, unless the optional feature is enabled.
- Waveform for N>=2:
  - H = floor(N/2), L = N-H.
  - clk_out is high for H clk_in cycles, then low for L cycles, repeating with period N cycles.
  - Even N gives 50% duty; odd N has the extra cycle in the low phase.
- Latency: the first rising edge of clk_in with power_down sampled 0 drives clk_out to 1. This gives one edge of latency from release.
- Counter:
  - counts 0..N-1;
  - clk_out <= 1 when the next count < H, else 0;
  - wraps N-1 -> 0 at the start of each period.
- N=0: clk_out held 0 (divider off); counter held at 0.
- N=1: bypass; clk_out = clk_in (static combinational mux selected by the latched N); the registered path is held at 0.
- clk_out is a registered flop output in all modes except the N=1 bypass. No combinational glitches are allowed on ratio change.
- power_down asserted mid-period: clk_out goes 0 at the next edge regardless of phase. There is no period completion; a truncated high pulse is acceptable.
- power_down and divide_by change on the same edge: the value present at that edge is loaded.
- Maximum N = 2^DIV_W - 1 = 255, giving H=127 and L=128.

Optional Feature:
- Macro: CLK_DIVIDER_LIVE_UPDATE_EN.
- Defined: while power_down=0, divide_by is re-sampled into N at the period boundary only (the edge where the counter wraps to 0). A ratio change therefore never produces a runt pulse; the new ratio applies to the next full period.
- Undefined: N is loaded only while power_down=1, as above.

Decomposition:
- Package clk_divider_pkg holds:
  - localparam DIV_W_DEFAULT = 8;
  - typedef logic [DIV_W-1:0] div_ratio_t;
  - named constants DIV_OFF = 0 and DIV_BYPASS = 1.
- One natural sub-module, clk_div_counter: the period counter with wrap and high/low phase compare, outputting next count and phase.
- The top level holds the ratio register, the bypass/off muxing and the optional live update.

Test Plan:
- power_down=1 for 1 cycle, N=2, release -> clk_out rises on the first edge after release; period 20 ns (2 clk_in cycles); 1 high / 1 low; holds for 1000 ns.
- Sequence pd=1, N=4, pd=0; then repeat for N=8, 16, 32, 64 -> periods 40/80/160/320/640 ns, each 50% duty, with clk_out=0 during every power_down window.
- N=5 -> clk_out 2 cycles high, 3 low, period 50 ns; N=255 -> 127 high / 128 low.
- Running at N=4, change divide_by to 8 without power_down:
  - macro undefined: stays at period 4;
  - macro defined: switches to period 8 at the next wrap with no short pulse.
- N=0 -> clk_out constant 0. N=1 -> clk_out follows clk_in.
- power_down asserted during the clk_out high phase at N=16 -> clk_out=0 on the next edge; after release, restarts high on the first edge.
